// File: rtl/register_file_pkg.sv
// Core-wide register-file types and constants shared with decode and the
// write-address select.
package register_file_pkg;

  localparam int         XLEN      = 32;
  localparam int         ADDR_W    = 5;
  localparam int         REG_COUNT = 32;
  localparam logic [4:0] X0_IDX    = 5'd0;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xword_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == COUNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational source-operand read port: reset forcing, x0 zeroing,
// write-to-read bypass, then storage lookup.
module rf_read_port #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic [XLEN-1:0]   i_regs [1:(2**ADDR_W)-1],
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_read_addr,
  input  logic              i_write_en,
  input  logic [ADDR_W-1:0] i_write_addr,
  input  logic [XLEN-1:0]   i_write_data,
  output logic [XLEN-1:0]   o_read_data
);
  import register_file_pkg::*;

  logic w_is_x0;
  logic w_bypass;

  assign w_is_x0  = (i_read_addr == X0_IDX);
  assign w_bypass = i_write_en && (i_write_addr == i_read_addr);

  // Priority read mux: reset, x0, bypass, storage.
  always_comb begin
    o_read_data = {XLEN{1'b0}};
    if (i_reset) begin
      o_read_data = {XLEN{1'b0}};
    end else if (w_is_x0) begin
      o_read_data = {XLEN{1'b0}};
    end else if (w_bypass) begin
      o_read_data = i_write_data;
    end else begin
      o_read_data = i_regs[i_read_addr];
    end
  end

endmodule

// File: rtl/register_file.sv
// Integer register file x0-x31 with two bypassed combinational read ports
// and a saturating count of committed non-x0 writes.
module register_file #(
  parameter int XLEN   = register_file_pkg::XLEN,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [XLEN-1:0]   WriteData,
  input  logic [ADDR_W-1:0] ReadAddr_A,
  input  logic [ADDR_W-1:0] ReadAddr_B,
  output logic [XLEN-1:0]   ReadData_A,
  output logic [XLEN-1:0]   ReadData_B,
  output logic [15:0]       WriteCount
);
  import register_file_pkg::*;

  localparam int NREGS = 2**ADDR_W;

  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic [15:0]     r_write_count;
  logic            w_commit;

  assign w_commit = WriteEn && (WriteAddr != X0_IDX);

  // Storage: per-register equality decode so an unknown address writes nothing.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (WriteEn && (WriteAddr == ADDR_W'(i))) begin
          r_regs[i] <= WriteData;
        end
      end
    end
  end

  // Saturating committed-write counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_write_count <= 16'd0;
    end else if (w_commit) begin
      r_write_count <= sat_inc16(r_write_count);
    end
  end

  assign WriteCount = r_write_count;

  rf_read_port #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_port_a (
    .i_regs       (r_regs),
    .i_reset      (Reset),
    .i_read_addr  (ReadAddr_A),
    .i_write_en   (WriteEn),
    .i_write_addr (WriteAddr),
    .i_write_data (WriteData),
    .o_read_data  (ReadData_A)
  );

  rf_read_port #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_port_b (
    .i_regs       (r_regs),
    .i_reset      (Reset),
    .i_read_addr  (ReadAddr_B),
    .i_write_en   (WriteEn),
    .i_write_addr (WriteAddr),
    .i_write_data (WriteData),
    .o_read_data  (ReadData_B)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed plus random scoreboard bench for register_file.
module tb_register_file;

  logic        Clk;
  logic        Reset;
  logic        WriteEn;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [4:0]  ReadAddr_A;
  logic [4:0]  ReadAddr_B;
  logic [31:0] ReadData_A;
  logic [31:0] ReadData_B;
  logic [15:0] WriteCount;

  register_file dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .WriteEn    (WriteEn),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .ReadAddr_A (ReadAddr_A),
    .ReadAddr_B (ReadAddr_B),
    .ReadData_A (ReadData_A),
    .ReadData_B (ReadData_B),
    .WriteCount (WriteCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_rd_t;

  exp_rd_t     rd_q [$];
  logic [15:0] cnt_q [$];

  logic [31:0] m_regs [32];
  logic [15:0] m_count;
  int          n_assert;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra);
    if (Reset)                          return 32'd0;
    if (ra == 5'd0)                     return 32'd0;
    if (WriteEn && (WriteAddr == ra))   return WriteData;
    return m_regs[ra];
  endfunction

  // One clock of stimulus: drive, check combinational reads, clock, check count.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    exp_rd_t e;
    logic [15:0] ec;
    @(negedge Clk);
    Reset = rst; WriteEn = we; WriteAddr = wa; WriteData = wd;
    ReadAddr_A = ra; ReadAddr_B = rb;
    e.a = model_read(ra);
    e.b = model_read(rb);
    rd_q.push_back(e);
    #1;
    if (rd_q.size() == 0) begin
      check("rd_q_empty", 32'd1, 32'd0);
    end else begin
      e = rd_q.pop_front();
      check("read_a", ReadData_A, e.a);
      check("read_b", ReadData_B, e.b);
    end
    @(posedge Clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 16'd0;
    end else if (we && (wa != 5'd0)) begin
      m_regs[wa] = wd;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end
    cnt_q.push_back(m_count);
    #1;
    if (cnt_q.size() == 0) begin
      check("cnt_q_empty", 32'd1, 32'd0);
    end else begin
      ec = cnt_q.pop_front();
      check("write_count", {16'd0, WriteCount}, {16'd0, ec});
    end
  endtask

  initial begin
    logic [4:0] wa;
    n_assert = 0;
    n_fail   = 0;
    m_count  = 16'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    Reset = 1'b1; WriteEn = 1'b0; WriteAddr = 5'd0; WriteData = 32'd0;
    ReadAddr_A = 5'd0; ReadAddr_B = 5'd0;

    // Reset held two cycles; reads forced to zero even with a bypass hit.
    step(1'b1, 1'b1, 5'd3, 32'hCAFE0003, 5'd3, 5'd3);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31);

    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
    end

    // Plain write, read back next cycle on both ports.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    check("x5_count_one", {16'd0, WriteCount}, 32'd1);

    // Same-cycle bypass, then stored value.
    step(1'b0, 1'b1, 5'd7, 32'h00001234, 5'd7, 5'd5);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);

    // x0 write is ignored.
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7);

    // Reset wins over a concurrent write.
    step(1'b0, 1'b1, 5'd9, 32'h11111111, 5'd1, 5'd2);
    step(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd5);
    check("post_reset_count", {16'd0, WriteCount}, 32'd0);

    // Fill x1..x31 with index-dependent values.
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(i - 1));
    end
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i));
    end

    // Random dual reads with interleaved writes and bypass hits.
    for (int n = 0; n < 1000; n++) begin
      wa = 5'($urandom_range(0, 31));
      step(1'b0, 1'($urandom_range(0, 1)), wa, $urandom,
           ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)));
    end

    // Saturation: 65540 committed writes after a fresh reset.
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int n = 0; n < 65540; n++) begin
      wa = 5'($urandom_range(1, 31));
      step(1'b0, 1'b1, wa, 32'(n), wa, 5'($urandom_range(0, 31)));
    end
    check("count_saturated", {16'd0, WriteCount}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
